// File: rtl/csa_accum_sequencer.sv
// Frame accumulator: two operands plus running sum per beat through a
// three-operand carry-save adder, result presented on a valid/ready port.
module csa_accum_sequencer #(
    parameter int W         = 4,
    parameter int ACC_W     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    input  logic             op_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_sum,
    output logic [7:0]       res_beats,
    output logic             res_ovf,
    output logic             res_trunc
);

    localparam int N = ACC_W + 1;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [7:0]       beats, beats_n;
    logic             ovf, ovf_n;
    logic             trunc, trunc_n;

    logic [N-1:0] x, y, z, ps, maj, pc, tot;
    logic         rc;
    logic         accept, limit;

    assign x = {1'b0, acc};
    assign y = {{(N-W){1'b0}}, op_a};
    assign z = {{(N-W){1'b0}}, op_b};

    // 3:2 compression, then a ripple resolve of sum and shifted carry
    assign ps  = x ^ y ^ z;
    assign maj = (x & y) | (x & z) | (y & z);
    assign pc  = {maj[N-2:0], 1'b0};

    always_comb begin
        tot = '0;
        rc  = 1'b0;
        for (int i = 0; i < N; i++) begin
            tot[i] = ps[i] ^ pc[i] ^ rc;
            rc     = (ps[i] & pc[i]) | (ps[i] & rc) | (pc[i] & rc);
        end
    end

    assign op_ready  = (state != DONE);
    assign res_valid = (state == DONE);
    assign accept    = op_valid & op_ready;
    assign limit     = ((beats + 8'd1) == 8'(MAX_BEATS));

    assign res_sum   = acc;
    assign res_beats = beats;
    assign res_ovf   = ovf;
    assign res_trunc = trunc;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        beats_n = beats;
        ovf_n   = ovf;
        trunc_n = trunc;
        unique case (state)
            IDLE, ACC: begin
                if (accept) begin
                    acc_n   = tot[ACC_W-1:0];
                    ovf_n   = ovf | tot[ACC_W];
                    beats_n = beats + 8'd1;
                    if (op_last) begin
                        state_n = DONE;
                    end else if (limit) begin
                        state_n = DONE;
                        trunc_n = 1'b1;
                    end else begin
                        state_n = ACC;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_n = IDLE;
                    acc_n   = '0;
                    beats_n = '0;
                    ovf_n   = 1'b0;
                    trunc_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            beats <= '0;
            ovf   <= 1'b0;
            trunc <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            beats <= beats_n;
            ovf   <= ovf_n;
            trunc <= trunc_n;
        end
    end

endmodule

// File: tb/tb_csa_accum_sequencer.sv
// Scoreboard bench for csa_accum_sequencer: a per-frame reference model
// pushes expected results, which are popped when the DUT presents them.
module tb_csa_accum_sequencer;

    localparam int W = 4, ACC_W = 8, MAX_BEATS = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [W-1:0]     op_a = '0;
    logic [W-1:0]     op_b = '0;
    logic             op_last = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [ACC_W-1:0] res_sum;
    logic [7:0]       res_beats;
    logic             res_ovf;
    logic             res_trunc;

    csa_accum_sequencer #(.W(W), .ACC_W(ACC_W), .MAX_BEATS(MAX_BEATS)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_a(op_a), .op_b(op_b), .op_last(op_last),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_beats(res_beats),
        .res_ovf(res_ovf), .res_trunc(res_trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int beats;
        int ovf;
        int trunc;
    } res_t;

    res_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_true = 0;
    int   m_beats = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_true  = 0;
        m_beats = 0;
    endtask

    // drive one beat and hold it until accepted
    task automatic beat(input int a, input int b, input bit last);
        int n = 0;
        res_t r;
        op_valid = 1'b1;
        op_a     = W'(a);
        op_b     = W'(b);
        op_last  = last;
        while (!op_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100) check("beat_timeout", 0, 1);
        m_true += a + b;
        m_beats++;
        if (last || m_beats == MAX_BEATS) begin
            r.sum   = m_true % 256;
            r.beats = m_beats;
            r.ovf   = (m_true > 255) ? 1 : 0;
            r.trunc = last ? 0 : 1;
            sb.push_back(r);
            model_clear();
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_last  = 1'b0;
    endtask

    task automatic collect(input string tag);
        int n = 0;
        res_t r;
        while (!res_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 100 || sb.size() == 0) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            r = sb.pop_front();
            check({tag, "_sum"},   int'(res_sum),   r.sum);
            check({tag, "_beats"}, int'(res_beats), r.beats);
            check({tag, "_ovf"},   int'(res_ovf),   r.ovf);
            check({tag, "_trunc"}, int'(res_trunc), r.trunc);
            check({tag, "_rdy"},   int'(op_ready),  0);
            res_ready = 1'b1;
            @(posedge clk); #1;
            res_ready = 1'b0;
            check({tag, "_gap_rdy"}, int'(op_ready),  1);
            check({tag, "_gap_val"}, int'(res_valid), 0);
        end
    endtask

    initial begin
        #12;
        check("rst_valid", int'(res_valid), 0);
        check("rst_ready", int'(op_ready),  1);
        check("rst_sum",   int'(res_sum),   0);
        check("rst_beats", int'(res_beats), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        beat(15, 15, 1);
        check("single_valid", int'(res_valid), 1);
        @(posedge clk); #1;
        check("single_hold_rdy", int'(op_ready), 0);
        collect("single");

        beat(3, 4, 0);
        check("b2b_live", int'(res_sum), 7);
        beat(5, 6, 0);
        beat(7, 8, 1);
        collect("b2b");
        beat(1, 1, 1);
        collect("after_b2b");

        for (int i = 1; i <= 9; i++) beat(15, 15, i == 9);
        collect("ovf9");
        beat(0, 0, 1);
        collect("ovf_clear");

        for (int i = 1; i <= 16; i++) beat(1, 0, 0);
        collect("trunc16");
        for (int i = 1; i <= 16; i++) beat(1, 0, i == 16);
        collect("last16");

        // result held while a pending beat waits
        beat(2, 2, 1);
        op_valid = 1'b1;
        op_a     = 4'd9;
        op_b     = 4'd9;
        op_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_rdy",   int'(op_ready),  0);
            check("hold_sum",   int'(res_sum),   4);
            check("hold_beats", int'(res_beats), 1);
        end
        collect("hold");
        beat(9, 9, 1);
        collect("pending");

        beat(5, 5, 0);
        beat(6, 6, 0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_sum",   int'(res_sum),   0);
        check("arst_beats", int'(res_beats), 0);
        check("arst_ready", int'(op_ready),  1);
        check("arst_valid", int'(res_valid), 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        beat(2, 3, 1);
        collect("post_rst");

        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
